// File: rtl/cyc_state_decoder.sv
// Cycle-control state decoder: registered phase decodes of the CC state, cycle
// length measurement between TERM samples, and sticky timeout/sequence-error flags.
module cyc_state_decoder (
    input  logic       CK,
    input  logic       RESET,
    input  logic       TERM_n,
    input  logic [3:0] CC_n,
    input  logic       BRK_n,
    input  logic       CLRERR,
    output logic       CYCDONE,
    output logic [4:0] CYCLEN,
    output logic       BUSY,
    output logic       PH_WAITBUS,
    output logic       PH_SLOW,
    output logic       PH_BRK,
    output logic       PH_LONG,
    output logic       TIMEOUT,
    output logic       SEQERR
);

    localparam logic [4:0] CNT_MAX = 5'd31;

    logic       term;
    logic       brk;
    logic [3:0] cc;

    assign term = ~TERM_n;
    assign brk  = ~BRK_n;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_cc_pol
            assign cc[gi] = ~CC_n[gi];
        end
    endgenerate

    logic [4:0] cnt_q,     cnt_d;
    logic [4:0] cyclen_q,  cyclen_d;
    logic       cycdone_q, cycdone_d;
    logic       busy_q,    busy_d;
    logic       waitbus_q, waitbus_d;
    logic       slow_q,    slow_d;
    logic       phbrk_q,   phbrk_d;
    logic       long_q,    long_d;
    logic       timeout_q, timeout_d;
    logic       seqerr_q,  seqerr_d;
    logic       prev_term_q;
    logic [3:0] prev_cc_q;

    logic cnt_sat;
    logic timeout_set;
    logic seqerr_set;

    always_comb begin
        cnt_sat = (cnt_q == CNT_MAX);

        cnt_d    = cnt_q;
        cyclen_d = cyclen_q;
        if (term) begin
            cnt_d    = 5'd0;
            cyclen_d = cnt_sat ? CNT_MAX : cnt_q + 5'd1;
        end else if (!cnt_sat) begin
            cnt_d = cnt_q + 5'd1;
        end

        cycdone_d = term;
        busy_d    = (cc != 4'b0000);
        waitbus_d = (cc == 4'b0010) || (cc == 4'b0110);
        slow_d    = (cc == 4'b0101);
        phbrk_d   = (cc == 4'b0111) && brk;
        long_d    = cc[3];

        // A cycle must start from idle after TERM, and may only return to idle via TERM.
        timeout_set = cnt_sat && !term;
        seqerr_set  = (prev_term_q && (cc != 4'b0000)) ||
                      ((prev_cc_q != 4'b0000) && (cc == 4'b0000) && !prev_term_q);

        // Set has priority over clear.
        timeout_d = timeout_set ? 1'b1 : (CLRERR ? 1'b0 : timeout_q);
        seqerr_d  = seqerr_set  ? 1'b1 : (CLRERR ? 1'b0 : seqerr_q);
    end

    always_ff @(posedge CK or posedge RESET) begin
        if (RESET) begin
            cnt_q       <= 5'd0;
            cyclen_q    <= 5'd0;
            cycdone_q   <= 1'b0;
            busy_q      <= 1'b0;
            waitbus_q   <= 1'b0;
            slow_q      <= 1'b0;
            phbrk_q     <= 1'b0;
            long_q      <= 1'b0;
            timeout_q   <= 1'b0;
            seqerr_q    <= 1'b0;
            prev_term_q <= 1'b0;
            prev_cc_q   <= 4'b0000;
        end else begin
            cnt_q       <= cnt_d;
            cyclen_q    <= cyclen_d;
            cycdone_q   <= cycdone_d;
            busy_q      <= busy_d;
            waitbus_q   <= waitbus_d;
            slow_q      <= slow_d;
            phbrk_q     <= phbrk_d;
            long_q      <= long_d;
            timeout_q   <= timeout_d;
            seqerr_q    <= seqerr_d;
            prev_term_q <= term;
            prev_cc_q   <= cc;
        end
    end

    assign CYCDONE    = cycdone_q;
    assign CYCLEN     = cyclen_q;
    assign BUSY       = busy_q;
    assign PH_WAITBUS = waitbus_q;
    assign PH_SLOW    = slow_q;
    assign PH_BRK     = phbrk_q;
    assign PH_LONG    = long_q;
    assign TIMEOUT    = timeout_q;
    assign SEQERR     = seqerr_q;

endmodule

// File: tb/tb_cyc_state_decoder.sv
// Directed bench for cyc_state_decoder: vector table for decodes and cycle lengths,
// hand sequences for timeout, error clear priority and asynchronous reset.
module tb_cyc_state_decoder;

    logic       CK = 1'b0;
    logic       RESET;
    logic       TERM_n;
    logic [3:0] CC_n;
    logic       BRK_n;
    logic       CLRERR;
    logic       CYCDONE;
    logic [4:0] CYCLEN;
    logic       BUSY;
    logic       PH_WAITBUS;
    logic       PH_SLOW;
    logic       PH_BRK;
    logic       PH_LONG;
    logic       TIMEOUT;
    logic       SEQERR;

    cyc_state_decoder dut (
        .CK         (CK),
        .RESET      (RESET),
        .TERM_n     (TERM_n),
        .CC_n       (CC_n),
        .BRK_n      (BRK_n),
        .CLRERR     (CLRERR),
        .CYCDONE    (CYCDONE),
        .CYCLEN     (CYCLEN),
        .BUSY       (BUSY),
        .PH_WAITBUS (PH_WAITBUS),
        .PH_SLOW    (PH_SLOW),
        .PH_BRK     (PH_BRK),
        .PH_LONG    (PH_LONG),
        .TIMEOUT    (TIMEOUT),
        .SEQERR     (SEQERR)
    );

    always #5 CK = ~CK;

    // {cycdone, cyclen[4:0], busy, waitbus, slow, brk, long, timeout, seqerr}
    logic [12:0] obs;
    assign obs = {CYCDONE, CYCLEN, BUSY, PH_WAITBUS, PH_SLOW, PH_BRK, PH_LONG, TIMEOUT, SEQERR};

    typedef struct {
        logic        term;
        logic [3:0]  cc;
        logic        brk;
        logic        clr;
        logic [12:0] exp;
    } vec_t;

    int errors = 0;
    int checks = 0;

    function automatic vec_t v(input logic term, input logic [3:0] cc, input logic brk,
                               input logic clr, input logic done, input logic [4:0] len,
                               input logic busy, input logic wb, input logic slow,
                               input logic pb, input logic lg, input logic to,
                               input logic se);
        vec_t r;
        r.term = term;
        r.cc   = cc;
        r.brk  = brk;
        r.clr  = clr;
        r.exp  = {done, len, busy, wb, slow, pb, lg, to, se};
        return r;
    endfunction

    task automatic check(input string name, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b expected=%b", name, got, exp);
        end else begin
            $display("ok   %s value=%b", name, got);
        end
    endtask

    task automatic drive(input logic term, input logic [3:0] cc, input logic brk, input logic clr);
        TERM_n = ~term;
        CC_n   = ~cc;
        BRK_n  = ~brk;
        CLRERR = clr;
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    vec_t vecs [30];

    initial begin
        // short cycle: TERM every clock in idle
        for (int i = 0; i < 4; i++) vecs[i] = v(1, 4'b0000, 0, 0, 1, 5'd1, 0, 0, 0, 0, 0, 0, 0);
        // 100ns cycle
        vecs[4]  = v(0, 4'b0000, 0, 0, 0, 5'd1, 0, 0, 0, 0, 0, 0, 0);
        vecs[5]  = v(0, 4'b0001, 0, 0, 0, 5'd1, 1, 0, 0, 0, 0, 0, 0);
        vecs[6]  = v(1, 4'b0011, 0, 0, 1, 5'd3, 1, 0, 0, 0, 0, 0, 0);
        vecs[7]  = v(0, 4'b0000, 0, 0, 0, 5'd3, 0, 0, 0, 0, 0, 0, 0);
        // wait and slow phases
        vecs[8]  = v(0, 4'b0010, 0, 0, 0, 5'd3, 1, 1, 0, 0, 0, 0, 0);
        vecs[9]  = v(0, 4'b0110, 0, 0, 0, 5'd3, 1, 1, 0, 0, 0, 0, 0);
        vecs[10] = v(0, 4'b0101, 0, 0, 0, 5'd3, 1, 0, 1, 0, 0, 0, 0);
        vecs[11] = v(1, 4'b0101, 0, 0, 1, 5'd5, 1, 0, 1, 0, 0, 0, 0);
        vecs[12] = v(0, 4'b0000, 0, 0, 0, 5'd5, 0, 0, 0, 0, 0, 0, 0);
        // long phases; 1111 with BRK is not a break phase
        vecs[13] = v(0, 4'b1001, 0, 0, 0, 5'd5, 1, 0, 0, 0, 1, 0, 0);
        vecs[14] = v(0, 4'b1111, 1, 0, 0, 5'd5, 1, 0, 0, 0, 1, 0, 0);
        vecs[15] = v(1, 4'b1100, 0, 0, 1, 5'd4, 1, 0, 0, 0, 1, 0, 0);
        vecs[16] = v(0, 4'b0000, 0, 0, 0, 5'd4, 0, 0, 0, 0, 0, 0, 0);
        // break cycle right after a TERM (flags a sequence error)
        vecs[17] = v(1, 4'b0000, 0, 0, 1, 5'd2, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 18; i < 23; i++) vecs[i] = v(0, 4'b0111, 1, 0, 0, 5'd2, 1, 0, 0, 1, 0, 0, 1);
        vecs[23] = v(1, 4'b0111, 0, 0, 1, 5'd6, 1, 0, 0, 0, 0, 0, 1);
        vecs[24] = v(0, 4'b0000, 0, 1, 0, 5'd6, 0, 0, 0, 0, 0, 0, 0);
        // return to idle without TERM
        vecs[25] = v(0, 4'b0011, 0, 0, 0, 5'd6, 1, 0, 0, 0, 0, 0, 0);
        vecs[26] = v(0, 4'b0000, 0, 0, 0, 5'd6, 0, 0, 0, 0, 0, 0, 1);
        vecs[27] = v(0, 4'b0000, 0, 1, 0, 5'd6, 0, 0, 0, 0, 0, 0, 0);
        vecs[28] = v(1, 4'b0101, 1, 0, 1, 5'd5, 1, 0, 1, 0, 0, 0, 0);
        vecs[29] = v(0, 4'b0000, 1, 0, 0, 5'd5, 0, 0, 0, 0, 0, 0, 0);

        RESET = 1'b1;
        drive(0, 4'b0000, 0, 0);
        #12;
        check("reset_state", obs, 13'd0);
        @(negedge CK);
        RESET = 1'b0;

        for (int i = 0; i < 30; i++) begin
            drive(vecs[i].term, vecs[i].cc, vecs[i].brk, vecs[i].clr);
            step();
            check($sformatf("vec%0d term=%b cc=%b brk=%b clr=%b", i, vecs[i].term,
                            vecs[i].cc, vecs[i].brk, vecs[i].clr), obs, vecs[i].exp);
        end

        // timeout: 40 clocks without TERM after a TERM
        drive(1, 4'b0000, 0, 0);
        step();
        check("to_last_term_cyclen", {8'd0, CYCLEN}, 13'd2);
        for (int k = 1; k <= 40; k++) begin
            drive(0, 4'b1000, 0, 0);
            step();
            check($sformatf("to_wait%0d", k), {12'd0, TIMEOUT}, {12'd0, (k >= 32) ? 1'b1 : 1'b0});
        end
        drive(1, 4'b1000, 0, 0);
        step();
        check("to_term_sat", obs, {1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
        drive(0, 4'b0000, 0, 0);
        step();
        check("to_sticky", {12'd0, TIMEOUT}, 13'd1);
        drive(0, 4'b0000, 0, 1);
        step();
        check("to_clear", obs, {1'b0, 5'd31, 7'd0});

        // sequence error with CLRERR coinciding with a new violation
        drive(1, 4'b0000, 0, 0); step(); check("se_a_term", {12'd0, SEQERR}, 13'd0);
        drive(0, 4'b0011, 0, 0); step(); check("se_a_set", {12'd0, SEQERR}, 13'd1);
        drive(1, 4'b0011, 0, 0); step(); check("se_a_hold", {12'd0, SEQERR}, 13'd1);
        drive(0, 4'b0011, 0, 1); step(); check("se_set_beats_clr", {12'd0, SEQERR}, 13'd1);
        drive(1, 4'b0011, 0, 1); step(); check("se_clr", {12'd0, SEQERR}, 13'd0);
        drive(0, 4'b0000, 0, 0); step(); check("se_idle", {12'd0, SEQERR}, 13'd0);

        // async reset with CNT = 7
        for (int k = 0; k < 6; k++) begin
            drive(0, 4'b0001, 0, 0);
            step();
        end
        check("rst_pre_busy", {8'd0, BUSY, CYCLEN}, {8'd0, 1'b1, 5'd2});
        #2;
        drive(0, 4'b0000, 0, 0);
        RESET = 1'b1;
        #1;
        check("rst_async", obs, 13'd0);
        @(negedge CK);
        RESET = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check($sformatf("rst_post%0d", k), obs, 13'd0);
        end
        drive(1, 4'b0000, 0, 0);
        step();
        check("rst_first_term", obs, {1'b1, 5'd5, 7'd0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
